// File: rtl/lbw_pkg.sv
// Shared types and helpers for the line burst writer: drain FSM states,
// ping-pong bank index and a constant-foldable ceil_log2.
package lbw_pkg;

   typedef enum logic [1:0] {
      DR_IDLE     = 2'd0,
      DR_START    = 2'd1,
      DR_PREFETCH = 2'd2,
      DR_BURST    = 2'd3
   } drain_state_t;

   typedef logic bank_idx_t;

   // Never returns less than 1 so that single-entry counters still get a bit.
   function automatic int ceil_log2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 32; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/lbw_line_bank.sv
// Two line buffers behind one write port and one registered read port;
// the bank select picks which buffer each port addresses.
module lbw_line_bank
   import lbw_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int PIX_W = 16,
   parameter int IDX_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  bank_idx_t        wr_bank,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             rd_en,
   input  bank_idx_t        rd_bank,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [PIX_W-1:0] rd_data
);

   logic [PIX_W-1:0] mem0 [DEPTH];
   logic [PIX_W-1:0] mem1 [DEPTH];

   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_bank == 1'b0)) begin
         mem0[wr_addr] <= wr_data;
      end
      if (wr_en && (wr_bank == 1'b1)) begin
         mem1[wr_addr] <= wr_data;
      end
   end

   // Read register only moves on a read, so the word holds through stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (rd_bank == 1'b1) ? mem1[rd_addr] : mem0[rd_addr];
      end
   end

endmodule

// File: rtl/line_burst_writer.sv
// Captures video lines into ping-pong banks and drains each full line to
// external RAM as a handshaked burst. Define LBW_DROP_COUNT_EN for drop_count.
module line_burst_writer
   import lbw_pkg::*;
#(
   parameter int H_RES_PIX = 640,
   parameter int V_RES_PIX = 480,
   parameter int PIX_W     = 16,
   parameter int ADDR_W    = 23,
   parameter int BASE_ADDR = 0
) (
   input  logic              mem_clk,
   input  logic              rst,
   input  logic              v_sync,
   input  logic              data_valid,
   input  logic [PIX_W-1:0]  DATA_in,
   output logic              start_external_ram_write,
   output logic [ADDR_W-1:0] external_ram_write_address,
   output logic [PIX_W-1:0]  Memory_Data,
   output logic              WRITE,
   input  logic              ReadyWrite,
   output logic              overflow
`ifdef LBW_DROP_COUNT_EN
   ,output logic [15:0]      drop_count
`endif
);

   localparam int IDX_W = ceil_log2(H_RES_PIX);
   localparam int V_W   = ceil_log2(V_RES_PIX + 1);
   localparam logic [IDX_W-1:0]  H_LAST   = IDX_W'(H_RES_PIX - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [V_W-1:0]    V_END    = V_W'(V_RES_PIX);
   localparam logic [V_W-1:0]    V_ONE    = V_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic              vs_prev_r;
   logic              armed_r;
   logic [IDX_W-1:0]  h_cnt_r;
   logic [V_W-1:0]    v_cnt_r;
   bank_idx_t         fill_bank_r;
   bank_idx_t         drain_bank_r;
   logic [1:0]        full_r;
   logic [V_W-1:0]    tag_r [2];
   logic              overflow_r;

   drain_state_t      state_r;
   drain_state_t      state_nxt;
   logic [IDX_W-1:0]  word_idx_r;
   logic              write_r;
   logic              start_r;
   logic [ADDR_W-1:0] addr_r;

   logic              sof_s;
   logic              capture_s;
   logic              line_done_s;
   logic              fill_free_s;
   logic              wr_en_s;
   logic              accept_s;
   logic              release_s;
   logic              rd_en_s;
   logic [IDX_W-1:0]  rd_addr_s;
   logic [ADDR_W-1:0] line_base_s;
   logic [PIX_W-1:0]  rd_data_s;

   // Capture qualification; a bank released this very cycle counts as free.
   always_comb begin
      sof_s       = v_sync & ~vs_prev_r;
      capture_s   = armed_r & data_valid & (v_cnt_r < V_END) & ~sof_s;
      line_done_s = capture_s & (h_cnt_r == H_LAST);
      fill_free_s = ~full_r[fill_bank_r] | (release_s & (drain_bank_r == fill_bank_r));
      wr_en_s     = capture_s & fill_free_s;
      line_base_s = ADDR_W'(BASE_ADDR) + ADDR_W'(tag_r[drain_bank_r]) * ADDR_W'(H_RES_PIX);
   end

   // Line counters, bank ownership and the sticky overflow flag.
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         vs_prev_r   <= 1'b1;
         armed_r     <= 1'b0;
         h_cnt_r     <= '0;
         v_cnt_r     <= '0;
         fill_bank_r <= 1'b0;
         full_r      <= 2'b00;
         tag_r[0]    <= '0;
         tag_r[1]    <= '0;
         overflow_r  <= 1'b0;
      end else begin
         vs_prev_r <= v_sync;
         if (release_s) begin
            full_r[drain_bank_r] <= 1'b0;
         end
         if (sof_s) begin
            h_cnt_r    <= '0;
            v_cnt_r    <= '0;
            armed_r    <= 1'b1;
            overflow_r <= 1'b0;
         end else if (line_done_s) begin
            h_cnt_r <= '0;
            v_cnt_r <= v_cnt_r + V_ONE;
            // A dropped line leaves the fill bank in place so it is retried next line.
            if (fill_free_s) begin
               full_r[fill_bank_r] <= 1'b1;
               tag_r[fill_bank_r]  <= v_cnt_r;
               fill_bank_r         <= ~fill_bank_r;
            end else begin
               overflow_r <= 1'b1;
            end
         end else if (capture_s) begin
            h_cnt_r <= h_cnt_r + IDX_ONE;
         end
      end
   end

`ifdef LBW_DROP_COUNT_EN
   logic [15:0] drop_cnt_r;

   // Saturating count of dropped lines, untouched by SOF.
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         drop_cnt_r <= 16'h0000;
      end else if (line_done_s && !fill_free_s && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
   end

   assign drop_count = drop_cnt_r;
`endif

   // Drain FSM next state and bank read requests.
   always_comb begin
      state_nxt = state_r;
      rd_en_s   = 1'b0;
      rd_addr_s = '0;
      release_s = 1'b0;
      accept_s  = (state_r == DR_BURST) & write_r & ReadyWrite;
      case (state_r)
         DR_IDLE: begin
            if (full_r[drain_bank_r]) begin
               state_nxt = DR_START;
            end else begin
               state_nxt = DR_IDLE;
            end
         end
         DR_START: begin
            state_nxt = DR_PREFETCH;
         end
         DR_PREFETCH: begin
            rd_en_s   = 1'b1;
            state_nxt = DR_BURST;
         end
         DR_BURST: begin
            if (accept_s && (word_idx_r == H_LAST)) begin
               release_s = 1'b1;
               state_nxt = DR_IDLE;
            end else if (accept_s) begin
               rd_en_s   = 1'b1;
               rd_addr_s = word_idx_r + IDX_ONE;
            end else begin
               state_nxt = DR_BURST;
            end
         end
         default: begin
            state_nxt = DR_IDLE;
         end
      endcase
   end

   // Drain state, registered handshake outputs and the running word address.
   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state_r      <= DR_IDLE;
         drain_bank_r <= 1'b0;
         word_idx_r   <= '0;
         write_r      <= 1'b0;
         start_r      <= 1'b0;
         addr_r       <= '0;
      end else begin
         state_r <= state_nxt;
         write_r <= (state_nxt == DR_BURST);
         start_r <= (state_nxt == DR_START);
         if (state_r == DR_PREFETCH) begin
            addr_r     <= line_base_s;
            word_idx_r <= '0;
         end else if (accept_s) begin
            addr_r     <= addr_r + ADDR_ONE;
            word_idx_r <= word_idx_r + IDX_ONE;
         end
         if (release_s) begin
            drain_bank_r <= ~drain_bank_r;
         end
      end
   end

   lbw_line_bank #(
      .DEPTH (H_RES_PIX),
      .PIX_W (PIX_W),
      .IDX_W (IDX_W)
   ) u_bank (
      .clk     (mem_clk),
      .rst     (rst),
      .wr_en   (wr_en_s),
      .wr_bank (fill_bank_r),
      .wr_addr (h_cnt_r),
      .wr_data (DATA_in),
      .rd_en   (rd_en_s),
      .rd_bank (drain_bank_r),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   assign start_external_ram_write   = start_r;
   assign external_ram_write_address = addr_r;
   assign Memory_Data                = rd_data_s;
   assign WRITE                      = write_r;
   assign overflow                   = overflow_r;

endmodule

// File: doc/line_burst_writer.md
LINE_BURST_WRITER -- requirements
Module: line_burst_writer

Interface
REQ-001 SHALL have parameter H_RES_PIX, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter V_RES_PIX, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter PIX_W, default 16, meaning pixel and memory word width.
REQ-004 SHALL have parameter ADDR_W, default 23, meaning external RAM word-address width.
REQ-005 SHALL have parameter BASE_ADDR, default 0, meaning frame base word address.
REQ-006 SHALL have port mem_clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port v_sync, input, 1 bit: frame sync level; a rising edge marks start of frame (SOF).
REQ-009 SHALL have port data_valid, input, 1 bit: DATA_in holds an active pixel this cycle.
REQ-010 SHALL have port DATA_in, input, PIX_W bits: pixel data.
REQ-011 SHALL have port start_external_ram_write, output, 1 bit: one-cycle pulse at the start of each line burst.
REQ-012 SHALL have port external_ram_write_address, output, ADDR_W bits: word address of the current Memory_Data.
REQ-013 SHALL have port Memory_Data, output, PIX_W bits: word to write.
REQ-014 SHALL have port WRITE, output, 1 bit: Memory_Data and address valid; held until accepted.
REQ-015 SHALL have port ReadyWrite, input, 1 bit: memory accepts the word when WRITE and ReadyWrite are both high.
REQ-016 SHALL have port overflow, output, 1 bit: sticky, set on a dropped line, cleared at SOF.

Function
REQ-017 SHALL detect SOF as v_sync sampled 0 then 1 on consecutive cycles.
REQ-018 SHALL, on SOF, zero h_cnt and v_cnt, discard any partially received line, and arm capture; a drain in progress SHALL complete.
REQ-019 SHALL write each data_valid pixel into the current fill bank at h_cnt, then increment h_cnt.
REQ-020 SHALL, on the pixel with h_cnt=H_RES_PIX-1, mark the bank full, tag it with v_cnt, switch the fill bank, zero h_cnt and increment v_cnt.
REQ-021 SHALL ignore pixels after v_cnt reaches V_RES_PIX until the next SOF.
REQ-022 SHALL use two line banks (ping-pong), each H_RES_PIX x PIX_W, with a 1-cycle synchronous read.
REQ-023 SHALL, when a line completes while the other bank is still full, drop the new line (bank not marked full, v_cnt still increments) and set overflow.
REQ-024 SHALL treat a bank released in the same cycle a line completes as free (no overflow).
REQ-025 SHALL implement drain FSM IDLE->START->PREFETCH->BURST->IDLE: IDLE waits for a full bank; START pulses start_external_ram_write; PREFETCH issues a read of word 0; BURST asserts WRITE.
REQ-026 SHALL advance the word index on each WRITE&&ReadyWrite, prefetching the next word so that back-to-back acceptance yields one word per cycle.
REQ-027 SHALL drive external_ram_write_address = BASE_ADDR + tag*H_RES_PIX + word index, truncated to ADDR_W bits.
REQ-028 SHALL, on acceptance of word H_RES_PIX-1, deassert WRITE, release the bank and return to IDLE; a ready bank SHALL be serviced oldest-first.
REQ-029 SHALL hold Memory_Data and external_ram_write_address stable while WRITE=1 and ReadyWrite=0.

Reset
REQ-030 SHALL, while rst=1, force FSM=IDLE, both banks empty, h_cnt=v_cnt=0, capture disarmed, and outputs WRITE=0, start_external_ram_write=0, overflow=0, Memory_Data=0, address=0; bank contents are not cleared.
REQ-031 SHALL, when reset is asserted mid-burst, abandon the burst immediately, with WRITE low on the next cycle.

Configuration
REQ-032 SHALL, with macro LBW_DROP_COUNT_EN defined, add output drop_count[15:0], which increments per dropped line, saturates at 16'hFFFF, and is cleared by rst only; without the macro, the port and counter SHALL be absent.

Structure
REQ-033 SHALL place the drain-state enum, the ceil_log2 function, and the bank-index typedef in package lbw_pkg.
REQ-034 SHALL implement the two banks in a sub-module lbw_line_bank (one write port, one synchronous read port, bank select).

Verification
REQ-035 SHALL cover: H_RES_PIX=8, V_RES_PIX=4, BASE_ADDR=100, one frame, ReadyWrite=1 -> 4 bursts at addresses 100..107, 108..115, 116..123, 124..131, with data matching input order.
REQ-036 SHALL cover: ReadyWrite toggled 1-0-1 during a burst -> address and data held while ReadyWrite=0, and no word skipped or duplicated.
REQ-037 SHALL cover: ReadyWrite=0 across 3 completed lines -> line 2 dropped, overflow=1, and drop_count=1 when LBW_DROP_COUNT_EN is defined; overflow clears at the next SOF.
REQ-038 SHALL cover: SOF after 5 of 8 pixels -> partial line never written, and the next line is written at BASE_ADDR+0.
REQ-039 SHALL cover: rst asserted on the 3rd word of a burst -> WRITE=0 on the following cycle, and the next frame writes from address 100.
REQ-040 SHALL cover: 6 lines delivered with V_RES_PIX=4 -> only 4 bursts, with lines 5 and 6 ignored.
